// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with a free-running cycle counter.
// TX and RX run independently; reads return registered data one cycle after the strobe.
module uart_mmio #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [7:0]  io_wdata,
  output logic [31:0] io_rdata,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic               serial_out_q, serial_out_d;

  logic               rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic               rx_ferr_q, rx_ferr_d;
  logic               rx_done;

  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic [31:0]        io_rdata_q, io_rdata_d;

  logic wr_tx, wr_clr, rd_status, rd_rxdata, tx_ready, ovr_set;

  assign wr_tx     = io_we && (io_addr == 8'h08);
  assign wr_clr    = io_we && (io_addr == 8'h18);
  assign rd_status = io_re && (io_addr == 8'h00);
  assign rd_rxdata = io_re && (io_addr == 8'h04);
  assign tx_ready  = (tx_state_q == S_IDLE);

  // serial_out is registered, so it is computed for the state being entered
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    serial_out_d = serial_out_q;
    case (tx_state_q)
      S_IDLE: begin
        serial_out_d = 1'b1;
        if (wr_tx) begin
          tx_shift_d   = io_wdata;
          tx_cnt_d     = '0;
          tx_state_d   = S_START;
          serial_out_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d     = '0;
          tx_bit_d     = '0;
          tx_state_d   = S_DATA;
          serial_out_d = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d   = S_STOP;
            serial_out_d = 1'b1;
          end else begin
            tx_bit_d     = tx_bit_q + 3'd1;
            tx_shift_d   = tx_shift_q >> 1;
            serial_out_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d     = '0;
          tx_state_d   = S_IDLE;
          serial_out_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // After a framing error RX parks in STOP until the line returns high
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_ferr_q) begin
          if (rx_sync2_q) begin
            rx_state_d = S_IDLE;
            rx_ferr_d  = 1'b0;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A completion coinciding with an rx_data read is not an overrun; a status
  // read coinciding with a fresh overrun reports it and keeps it set.
  always_comb begin
    ovr_set       = rx_done && rx_valid_q && !rd_rxdata;
    rx_data_d     = rx_done ? rx_shift_q : rx_data_q;
    rx_valid_d    = rx_done ? 1'b1 : (rd_rxdata ? 1'b0 : rx_valid_q);
    overrun_d     = ovr_set ? 1'b1 : (rd_status ? 1'b0 : overrun_q);
    cycle_count_d = wr_clr ? 32'd0 : cycle_count_q + 32'd1;
    io_rdata_d    = io_rdata_q;
    if (io_re) begin
      case (io_addr)
        8'h00:   io_rdata_d = {29'b0, overrun_q | ovr_set, rx_valid_q, tx_ready};
        8'h04:   io_rdata_d = {24'b0, rx_data_q};
        8'h10:   io_rdata_d = cycle_count_q;
        default: io_rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q    <= S_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      serial_out_q  <= 1'b1;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_ferr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      cycle_count_q <= '0;
      io_rdata_q    <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      serial_out_q  <= serial_out_d;
      rx_sync1_q    <= serial_in;
      rx_sync2_q    <= rx_sync1_q;
      rx_prev_q     <= rx_sync2_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      cycle_count_q <= cycle_count_d;
      io_rdata_q    <= io_rdata_d;
    end
  end

  assign io_rdata   = io_rdata_q;
  assign serial_out = serial_out_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at 8 clocks per bit: a timing-level model of the
// register file and serial lines is checked every cycle, plus directed literals.
module tb_uart_mmio;

  localparam int CPB    = 8;
  localparam int FRAME  = 10 * CPB;
  // first start-bit edge -> stop sample: 2 sync flops, half a bit, nine full bits
  localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

  logic        clk;
  logic        rst;
  logic [7:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_wdata;
  logic [31:0] io_rdata;
  logic        serial_in;
  logic        serial_out;

  uart_mmio #(.CPU_CLOCK_FREQ(800), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .serial_in(serial_in),
    .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ok;
  } rx_ev_t;

  rx_ev_t      rx_q[$];
  rx_ev_t      ev;
  int          cyc = 0;
  int          tx_s = -1;
  logic [7:0]  tx_b = 8'h00;
  logic [7:0]  m_rxdata = 8'h00;
  bit          m_valid = 1'b0;
  bit          m_ovr = 1'b0;
  logic [31:0] m_cc = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_so = 1'b1;
  int          last_done = 0;

  // Model: tx frame is a function of time since the accepted write; rx bytes
  // land at the scheduled completion edge of each frame the bench sends.
  initial begin
    bit         txr, done, set_ovr, rd_st, rd_rx;
    logic [7:0] nb;
    logic [9:0] fr;
    int         k;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        tx_s = -1; m_valid = 1'b0; m_ovr = 1'b0; m_rxdata = 8'h00;
        m_cc = 32'd0; exp_rdata = 32'd0; exp_so = 1'b1; rx_q.delete();
      end else begin
        cyc++;
        txr  = (tx_s < 0) || (cyc - 1 >= tx_s + FRAME);
        done = 1'b0; nb = 8'h00;
        if (rx_q.size() > 0 && rx_q[0].at == cyc) begin
          ev = rx_q.pop_front();
          done = ev.ok; nb = ev.b;
        end
        rd_st   = io_re && io_addr == 8'h00;
        rd_rx   = io_re && io_addr == 8'h04;
        set_ovr = done && m_valid && !rd_rx;
        if (io_re) begin
          if (io_addr == 8'h00)      exp_rdata = {29'd0, m_ovr | set_ovr, m_valid, txr};
          else if (io_addr == 8'h04) exp_rdata = {24'd0, m_rxdata};
          else if (io_addr == 8'h10) exp_rdata = m_cc;
          else                       exp_rdata = 32'd0;
        end
        if (io_we && io_addr == 8'h08 && txr) begin tx_s = cyc; tx_b = io_wdata; end
        m_cc = (io_we && io_addr == 8'h18) ? 32'd0 : m_cc + 32'd1;
        if (done) begin
          m_rxdata = nb; m_valid = 1'b1;
          if (set_ovr) m_ovr = 1'b1;
        end else if (rd_rx) begin
          m_valid = 1'b0;
        end
        if (rd_st && !set_ovr) m_ovr = 1'b0;
        if (tx_s >= 0 && cyc - tx_s < FRAME) begin
          fr = {1'b1, tx_b, 1'b0};
          k = (cyc - tx_s) / CPB;
          exp_so = fr[k];
        end else begin
          exp_so = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_tests++;
        if (serial_out !== exp_so) begin
          n_fail++;
          $display("FAIL model_serial_out cyc=%0d got %b expected %b", cyc, serial_out, exp_so);
        end
        n_tests++;
        if (io_rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL model_io_rdata cyc=%0d got 0x%08h expected 0x%08h", cyc, io_rdata, exp_rdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic io_read(input logic [7:0] a, output logic [31:0] d);
    io_addr = a; io_re = 1'b1;
    @(negedge clk);
    io_re = 1'b0;
    d = io_rdata;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] v);
    io_addr = a; io_wdata = v; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic wait_cyc(input int e);
    int guard = 0;
    while (cyc < e && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != e) begin
      n_tests++; n_fail++;
      $display("FAIL wait_cyc got %0d expected %0d", cyc, e);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    rx_ev_t     e;
    f = {stop_ok, b, 1'b0};
    e.at = cyc + 1 + RX_LAT; e.b = b; e.ok = stop_ok;
    rx_q.push_back(e);
    last_done = e.at;
    for (int i = 0; i < 10; i++) begin
      serial_in = f[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  a5_bits;
    rst = 1'b0; io_addr = 8'h00; io_we = 1'b0; io_re = 1'b0;
    io_wdata = 8'h00; serial_in = 1'b1;
    a5_bits = 10'b1_1010_0101_0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rdata", io_rdata, 32'd0);
    check("reset_serial_out", {31'd0, serial_out}, 32'd1);
    rst = 1'b1;

    io_read(8'h00, d);  check("reset_status", d, 32'h1);
    io_read(8'h10, d);  check("cc_after_reset", d, 32'd1);
    io_read(8'h08, d);  check("read_txdata_zero", d, 32'd0);
    io_write(8'h04, 8'hFF);
    io_write(8'h0C, 8'h55);
    io_read(8'h04, d);  check("rxdata_ro", d, 32'd0);

    // TX frame of 0xA5, status while busy, dropped write while busy
    io_write(8'h08, 8'hA5);
    io_read(8'h00, d);  check("status_busy", d, 32'h0);
    io_write(8'h08, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_a5_bit%0d", i), {31'd0, serial_out}, {31'd0, a5_bits[i]});
      repeat (CPB) @(negedge clk);
    end
    io_read(8'h00, d);  check("status_idle", d, 32'h1);

    // back-to-back write in the first idle cycle
    io_write(8'h08, 8'h3C);
    wait_cyc(tx_s + FRAME);
    io_write(8'h08, 8'hC3);
    check("b2b_start", {31'd0, serial_out}, 32'd0);
    repeat (FRAME + 2) @(negedge clk);

    // RX single frame
    send_frame(8'h3C, 1'b1);
    io_read(8'h00, d);  check("rx_status", d, 32'h3);
    io_read(8'h04, d);  check("rx_data", d, 32'h3C);
    io_read(8'h00, d);  check("rx_status_after", d, 32'h1);

    // two frames without a read: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    io_read(8'h00, d);  check("ovr_status", d, 32'h7);
    io_read(8'h00, d);  check("ovr_cleared", d, 32'h3);
    io_read(8'h04, d);  check("ovr_data", d, 32'h22);
    io_read(8'h00, d);  check("ovr_final", d, 32'h1);

    // glitch, framing error, then a good frame
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    repeat (12) @(negedge clk);
    io_read(8'h00, d);  check("glitch_status", d, 32'h1);
    send_frame(8'h77, 1'b0);
    io_read(8'h00, d);  check("ferr_status", d, 32'h1);
    send_frame(8'h5A, 1'b1);
    io_read(8'h04, d);  check("recover_data", d, 32'h5A);

    // completion coinciding with an rx_data read
    send_frame(8'hC3, 1'b1);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(negedge clk);
        wait_cyc(last_done - 1);
        io_read(8'h04, d);  check("coinc_rxdata_old", d, 32'hC3);
      end
    join
    io_read(8'h00, d);  check("coinc_keep_valid", d, 32'h3);
    io_read(8'h04, d);  check("coinc_rxdata_new", d, 32'h5A);

    // overrun set coinciding with a status read
    send_frame(8'h81, 1'b1);
    fork
      send_frame(8'h42, 1'b1);
      begin
        @(negedge clk);
        wait_cyc(last_done - 1);
        io_read(8'h00, d);  check("coinc_status_ovr", d, 32'h7);
      end
    join
    io_read(8'h00, d);  check("coinc_ovr_kept", d, 32'h7);
    io_read(8'h00, d);  check("coinc_ovr_clear", d, 32'h3);
    io_read(8'h04, d);  check("coinc_ovr_data", d, 32'h42);

    // TX write and RX completion on the same edge
    fork
      send_frame(8'h99, 1'b1);
      begin
        @(negedge clk);
        wait_cyc(last_done - 1);
        io_write(8'h08, 8'h66);
        check("simul_tx_start", {31'd0, serial_out}, 32'd0);
      end
    join
    repeat (FRAME) @(negedge clk);
    io_read(8'h04, d);  check("simul_rx_data", d, 32'h99);

    // cycle counter clear
    io_write(8'h18, 8'h00);
    io_read(8'h10, d);  check("cc_clear", d, 32'd0);
    repeat (5) @(negedge clk);
    io_read(8'h10, d);  check("cc_count", d, 32'd6);

    // reset during DATA bit 3 of a TX frame
    io_write(8'h08, 8'hA5);
    repeat (34) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_async_so", {31'd0, serial_out}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (9) @(negedge clk);
    io_read(8'h10, d);
    n_tests++;
    if (!(d == 32'd9 || d == 32'd10)) begin
      n_fail++;
      $display("FAIL cc_after_rst got %0d expected 9 or 10", d);
    end
    io_read(8'h00, d);  check("rst_status", d, 32'h1);
    repeat (FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
